psw_keypad_tx: RTL

Keypad-side sender for the four-digit password checker. It scans a 4x4 matrix keypad, debounces and decodes key presses, and forwards each digit as a `input_psw`/`enable` strobe pair in the order the checker expects. It also interprets the checker's 2-bit verdict and enforces a lockout after repeated failures. It sits between the keypad pins and the checker inside the lock top level.

---
 rtl/psw_pkg.sv | 49 ++++
 rtl/keypad_scan.sv | 115 +++++++++++
 rtl/psw_keypad_tx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/psw_pkg.sv
// psw_pkg: shared definitions for the keypad-side password sender.
//   - verdict codes exchanged with the password checker
//   - sequencer state encoding
//   - keypad code to digit map (code = row*4 + column)
package psw_pkg;

  localparam logic [1:0] PSW_NONE = 2'b00;
  localparam logic [1:0] PSW_FAIL = 2'b01;
  localparam logic [1:0] PSW_PASS = 2'b10;

  // Frame code {no_key, code}; MSB set means zero or several keys pressed.
  localparam logic [4:0] KEY_NONE = 5'b10000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DIGIT,
    ST_WAIT_RESP,
    ST_RELEASE,
    ST_LOCKED
  } seq_state_e;

  typedef struct packed {
    logic       is_digit;
    logic [3:0] digit;
  } key_digit_t;

  // Layout row-major from row 0: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic key_digit_t key_to_digit(input logic [3:0] code);
    key_digit_t r;
    r.is_digit = 1'b1;
    r.digit    = '0;
    case (code)
      4'd0:    r.digit = 4'd1;
      4'd1:    r.digit = 4'd2;
      4'd2:    r.digit = 4'd3;
      4'd4:    r.digit = 4'd4;
      4'd5:    r.digit = 4'd5;
      4'd6:    r.digit = 4'd6;
      4'd8:    r.digit = 4'd7;
      4'd9:    r.digit = 4'd8;
      4'd10:   r.digit = 4'd9;
      4'd13:   r.digit = 4'd0;
      default: r.is_digit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix scanner with frame capture and debounce.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   row_n_o[3:0]  : row drive, active low, one row at a time
//   col_n_i[3:0]  : column sense, active low (already synchronised)
//   key_code_o    : accepted key code (row*4 + column)
//   key_valid_o   : one-clock strobe per accepted press
module keypad_scan
  import psw_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [3:0] row_n_o,
  input  logic [3:0] col_n_i,
  output logic [3:0] key_code_o,
  output logic       key_valid_o
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_SCANS + 1);

  logic [DIV_W-1:0] div_q;
  logic [1:0]       row_q;
  logic [3:0]       row_n_q;
  logic [1:0]       cnt_q;      // keys seen so far this frame, saturates at 2
  logic [3:0]       code_q;
  logic [4:0]       frame_q;    // previous complete frame code
  logic [DB_W-1:0]  stable_q;
  logic             armed_q;    // set once "no key" has been debounced
  logic [3:0]       key_code_q;
  logic             key_valid_q;

  logic [2:0]      row_hits;
  logic [1:0]      hit_col;
  logic [3:0]      tot;
  logic [1:0]      cnt_sat;
  logic [3:0]      code_acc;
  logic [4:0]      frame_now;
  logic            sample;
  logic            frame_end;
  logic [DB_W-1:0] stable_nx;
  logic            accept;

  always_comb begin
    row_hits = '0;
    hit_col  = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (!col_n_i[c]) begin
        row_hits = row_hits + 3'd1;
        hit_col  = 2'(c);
      end
    end
    // Columns are sampled on the last clock a row is driven.
    sample    = (div_q == DIV_W'(SCAN_DIV - 1));
    frame_end = sample && (row_q == 2'd3);
    tot       = {2'b00, cnt_q} + {1'b0, row_hits};
    cnt_sat   = (tot >= 4'd2) ? 2'd2 : tot[1:0];
    code_acc  = (row_hits != 3'd0) ? {row_q, hit_col} : code_q;
    frame_now = (tot == 4'd1) ? {1'b0, code_acc} : KEY_NONE;
    stable_nx = (frame_now != frame_q) ? DB_W'(1) :
                (stable_q == DB_W'(DEBOUNCE_SCANS)) ? stable_q : stable_q + 1'b1;
    // Fires only on the frame where the run length first reaches the threshold.
    accept    = frame_end && (stable_nx == DB_W'(DEBOUNCE_SCANS)) &&
                !((frame_now == frame_q) && (stable_q == DB_W'(DEBOUNCE_SCANS)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q       <= '0;
      row_q       <= '0;
      row_n_q     <= 4'b1110;
      cnt_q       <= '0;
      code_q      <= '0;
      frame_q     <= KEY_NONE;
      stable_q    <= '0;
      armed_q     <= 1'b0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (sample) begin
        div_q   <= '0;
        row_q   <= row_q + 2'd1;
        row_n_q <= ~(4'b0001 << (row_q + 2'd1));
        if (frame_end) begin
          cnt_q    <= '0;
          code_q   <= '0;
          frame_q  <= frame_now;
          stable_q <= stable_nx;
          if (accept) begin
            if (frame_now[4]) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              key_valid_q <= 1'b1;
              key_code_q  <= frame_now[3:0];
              armed_q     <= 1'b0;
            end
          end
        end else begin
          cnt_q  <= cnt_sat;
          code_q <= code_acc;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign row_n_o     = row_n_q;
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;

endmodule

// File: rtl/psw_keypad_tx.sv
// psw_keypad_tx: keypad-side sender for the four-digit password checker.
//   clk, rst          : clock, synchronous active-high reset
//   row_n / col_n     : keypad row drive / column sense, active low
//   psw_result        : checker verdict (00 none, 01 wrong, 10 correct)
//   input_psw, enable : digit and strobe towards the checker
//   digit_count       : digits sent in the current attempt
//   locked            : high during lockout after repeated failures
//   result            : held outcome of the last attempt
module psw_keypad_tx
  import psw_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned RESP_WAIT      = 2,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCK_CYCLES    = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  input  logic [1:0] psw_result,
  output logic [3:0] input_psw,
  output logic       enable,
  output logic [2:0] digit_count,
  output logic       locked,
  output logic [1:0] result
);

  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int unsigned WAIT_W = $clog2(RESP_WAIT + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

  logic [3:0] key_code;
  logic       key_valid;
  key_digit_t kd;

  seq_state_e        state_q;
  logic [1:0]        ph_q;
  logic [3:0]        digit_q;
  logic [3:0]        input_psw_q;
  logic              enable_q;
  logic [2:0]        count_q;
  logic [FAIL_W-1:0] fails_q;
  logic              locked_q;
  logic [1:0]        result_q;
  logic [WAIT_W-1:0] wait_q;
  logic [LOCK_W-1:0] lock_q;

  keypad_scan #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scan (
    .clk_i       (clk),
    .rst_i       (rst),
    .row_n_o     (row_n),
    .col_n_i     (col_n),
    .key_code_o  (key_code),
    .key_valid_o (key_valid)
  );

  assign kd = key_to_digit(key_code);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ph_q        <= '0;
      digit_q     <= '0;
      input_psw_q <= '0;
      enable_q    <= 1'b0;
      count_q     <= '0;
      fails_q     <= '0;
      locked_q    <= 1'b0;
      result_q    <= PSW_NONE;
      wait_q      <= '0;
      lock_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (key_valid && kd.is_digit) begin
            digit_q <= kd.digit;
            ph_q    <= '0;
            if (count_q == 3'd0) begin
              result_q    <= PSW_NONE;
              input_psw_q <= '0;
              state_q     <= ST_START;
            end else begin
              input_psw_q <= kd.digit;
              state_q     <= ST_DIGIT;
            end
          end
        end
        // Arming strobe; phase 2 loads the digit so the zero stays stable
        // through the full strobe window.
        ST_START: begin
          ph_q <= ph_q + 2'd1;
          if (ph_q == 2'd0) begin
            enable_q <= 1'b1;
          end else if (ph_q == 2'd1) begin
            enable_q <= 1'b0;
          end else begin
            input_psw_q <= digit_q;
            ph_q        <= '0;
            state_q     <= ST_DIGIT;
          end
        end
        ST_DIGIT: begin
          if (ph_q == 2'd0) begin
            enable_q <= 1'b1;
            ph_q     <= 2'd1;
          end else begin
            enable_q <= 1'b0;
            count_q  <= count_q + 3'd1;
            wait_q   <= '0;
            state_q  <= ST_WAIT_RESP;
          end
        end
        ST_WAIT_RESP: begin
          if (wait_q == WAIT_W'(RESP_WAIT - 1)) begin
            if (psw_result == PSW_PASS) begin
              result_q    <= PSW_PASS;
              fails_q     <= '0;
              count_q     <= '0;
              input_psw_q <= '0;
              ph_q        <= '0;
              state_q     <= ST_RELEASE;
            end else if (psw_result == PSW_FAIL || count_q == 3'd4) begin
              result_q <= PSW_FAIL;
              count_q  <= '0;
              fails_q  <= fails_q + 1'b1;
              if (fails_q == FAIL_W'(MAX_FAILS - 1)) begin
                locked_q <= 1'b1;
                lock_q   <= '0;
                state_q  <= ST_LOCKED;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (ph_q == 2'd0) begin
            enable_q <= 1'b1;
            ph_q     <= 2'd1;
          end else begin
            enable_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (lock_q == LOCK_W'(LOCK_CYCLES - 1)) begin
            locked_q <= 1'b0;
            fails_q  <= '0;
            state_q  <= ST_IDLE;
          end else begin
            lock_q <= lock_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign input_psw   = input_psw_q;
  assign enable      = enable_q;
  assign digit_count = count_q;
  assign locked      = locked_q;
  assign result      = result_q;

endmodule
